axis_pkt_gen: RTL and testbench

Test-traffic source on the clk160m domain that builds Ethernet frames and drives them on the AXI-Stream TX side of the 10G MAC wrapper. The upstream neighbour of the xgmac top's axis_tx_* port. Frames are emitted as 64-bit beats in the MAC's lane order and excluding FCS, because the MAC appends the FCS. Software configures header fields, length, count and gap, then pulses start.

---
 rtl/axis_pkt_gen_pkg.sv | 22 ++
 rtl/axis_pkt_gen_if.sv | 11 +
 rtl/axis_pkt_gen_payload.sv | 59 +++++
 rtl/axis_pkt_gen.sv | 188 ++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkt_gen_pkg.sv
// rtl/axis_pkt_gen_pkg.sv - shared states, length limits, header offsets and tkeep helper for the packet generator
package axis_pkt_gen_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_IFG   = 2'd2;

  localparam int MIN_LEN_DEF = 60;
  localparam int MAX_LEN_DEF = 1514;

  localparam int OFF_DST     = 0;
  localparam int OFF_SRC     = 6;
  localparam int OFF_TYPE    = 12;
  localparam int OFF_SEQ     = 14;
  localparam int OFF_PAYLOAD = 18;

  // Byte enables of a frame's final beat from the length residue mod 8.
  function automatic logic [7:0] last_tkeep(input logic [2:0] r);
    return (r == 3'd0) ? 8'hFF : (8'hFF >> (4'd8 - {1'b0, r}));
  endfunction

endpackage

// File: rtl/axis_pkt_gen_if.sv
// rtl/axis_pkt_gen_if.sv - 64-bit AXI-Stream TX channel between the generator and the MAC
interface axis_pkt_gen_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tready;

  modport master (output tdata, tvalid, tkeep, tlast, input tready);
  modport slave  (input tdata, tvalid, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_pkt_gen_payload.sv
// rtl/axis_pkt_gen_payload.sv - 8 payload bytes per beat; PRBS-31 source when PKT_GEN_PRBS_EN is defined
module axis_pkt_gen_payload
  import axis_pkt_gen_pkg::*;
(
`ifdef PKT_GEN_PRBS_EN
  input  logic        clk,
  input  logic        rst,
  input  logic        seed,
  input  logic        advance,
`else
  input  logic [10:0] beat_idx,
`endif
  output logic [63:0] data
);

`ifdef PKT_GEN_PRBS_EN
  logic [30:0] lfsr_q, lfsr_d, lfsr_next;

  // x^31 + x^28 + 1, stepped 64 times; first generated bit lands in byte 0 bit 0.
  function automatic logic [94:0] prbs64(input logic [30:0] s);
    logic [30:0] st;
    logic [63:0] bits;
    logic        fb;
    st   = s;
    bits = '0;
    for (int n = 0; n < 64; n++) begin
      fb   = st[30] ^ st[27];
      bits = {fb, bits[63:1]};
      st   = {st[29:0], fb};
    end
    return {st, bits};
  endfunction

  always_comb begin
    {lfsr_next, data} = prbs64(lfsr_q);
    lfsr_d = lfsr_q;
    if (seed) begin
      lfsr_d = '1;
    end else if (advance) begin
      lfsr_d = lfsr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= '1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  for (genvar k = 0; k < 8; k++) begin : g_byte
    logic [13:0] off;
    assign off = {beat_idx, 3'(k)};
    assign data[8*k +: 8] = 8'(off - 14'(OFF_PAYLOAD));
  end
`endif

endmodule

// File: rtl/axis_pkt_gen.sv
// rtl/axis_pkt_gen.sv - Ethernet test-frame source for the 10G MAC TX stream; PKT_GEN_PRBS_EN selects PRBS payload
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int MIN_LEN = MIN_LEN_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int IFG_W   = 8
) (
  input  logic              clk160m,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [47:0]       dst_mac,
  input  logic [47:0]       src_mac,
  input  logic [15:0]       ethertype,
  input  logic [13:0]       frame_len,
  input  logic [31:0]       frame_count,
  input  logic [IFG_W-1:0]  ifg_cycles,
  axis_pkt_gen_if.master    axis_tx,
  output logic              busy,
  output logic              done,
  output logic [31:0]       frames_sent
);

  logic [1:0]       state_q, state_d;
  logic [10:0]      beat_idx_q, beat_idx_d, last_idx_q, last_idx_d;
  logic [2:0]       rem_q, rem_d;
  logic [47:0]      dst_q, dst_d, src_q, src_d;
  logic [15:0]      type_q, type_d;
  logic [31:0]      count_q, count_d, frames_sent_q, frames_sent_d;
  logic [IFG_W-1:0] ifg_q, ifg_d, ifg_cnt_q, ifg_cnt_d;
  logic             stop_pend_q, stop_pend_d, done_q, done_d;

  logic [13:0] clamped;
  logic        tvalid_w, xfer, last_beat;
  logic [31:0] fs_inc;
  logic [63:0] pay_data, data_w;
  logic [7:0]  keep_w;

  assign clamped   = (frame_len < 14'(MIN_LEN)) ? 14'(MIN_LEN) :
                     (frame_len > 14'(MAX_LEN)) ? 14'(MAX_LEN) : frame_len;
  assign tvalid_w  = (state_q == ST_FRAME);
  assign xfer      = tvalid_w & axis_tx.tready;
  assign last_beat = (beat_idx_q == last_idx_q);
  assign fs_inc    = frames_sent_q + 32'd1;
  assign keep_w    = !tvalid_w ? 8'h00 : (last_beat ? last_tkeep(rem_q) : 8'hFF);

  axis_pkt_gen_payload u_payload (
`ifdef PKT_GEN_PRBS_EN
    .clk      (clk160m),
    .rst      (reset),
    .seed     (state_q == ST_IDLE && start),
    .advance  (xfer && beat_idx_q >= 11'd2),
`else
    .beat_idx (beat_idx_q),
`endif
    .data     (pay_data)
  );

  // The sequence number of the frame on the wire equals frames completed so far.
  for (genvar k = 0; k < 8; k++) begin : g_lane
    logic [13:0] off;
    int          o;
    logic [7:0]  b;
    always_comb begin
      off = {beat_idx_q, 3'(k)};
      o   = int'(off);
      b   = 8'h00;
      if (o >= OFF_PAYLOAD) begin
        b = pay_data[8*k +: 8];
      end else if (o >= OFF_SEQ) begin
        b = 8'(frames_sent_q >> (8 * (OFF_PAYLOAD - 1 - o)));
      end else if (o >= OFF_TYPE) begin
        b = 8'(type_q >> (8 * (OFF_SEQ - 1 - o)));
      end else if (o >= OFF_SRC) begin
        b = 8'(src_q >> (8 * (OFF_TYPE - 1 - o)));
      end else if (o >= OFF_DST) begin
        b = 8'(dst_q >> (8 * (OFF_SRC - 1 - o)));
      end
    end
    assign data_w[8*k +: 8] = keep_w[k] ? b : 8'h00;
  end

  always_comb begin
    state_d       = state_q;
    beat_idx_d    = beat_idx_q;
    last_idx_d    = last_idx_q;
    rem_d         = rem_q;
    dst_d         = dst_q;
    src_d         = src_q;
    type_d        = type_q;
    count_d       = count_q;
    ifg_d         = ifg_q;
    ifg_cnt_d     = ifg_cnt_q;
    frames_sent_d = frames_sent_q;
    stop_pend_d   = stop_pend_q;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dst_d         = dst_mac;
          src_d         = src_mac;
          type_d        = ethertype;
          count_d       = frame_count;
          ifg_d         = ifg_cycles;
          rem_d         = clamped[2:0];
          last_idx_d    = 11'((clamped + 14'd7) >> 3) - 11'd1;
          beat_idx_d    = '0;
          frames_sent_d = '0;
          stop_pend_d   = 1'b0;
          state_d       = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (xfer) begin
          if (last_beat) begin
            frames_sent_d = fs_inc;
            beat_idx_d    = '0;
            if (stop_pend_q || stop || (count_q != 32'd0 && fs_inc == count_q)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (ifg_q != '0) begin
              state_d   = ST_IFG;
              ifg_cnt_d = ifg_q;
            end
          end else begin
            beat_idx_d = beat_idx_q + 11'd1;
          end
        end
      end
      ST_IFG: begin
        if (stop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (ifg_cnt_q == IFG_W'(1)) begin
          state_d = ST_FRAME;
        end else begin
          ifg_cnt_d = ifg_cnt_q - IFG_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk160m or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      beat_idx_q    <= '0;
      last_idx_q    <= '0;
      rem_q         <= '0;
      dst_q         <= '0;
      src_q         <= '0;
      type_q        <= '0;
      count_q       <= '0;
      ifg_q         <= '0;
      ifg_cnt_q     <= '0;
      frames_sent_q <= '0;
      stop_pend_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_idx_q    <= beat_idx_d;
      last_idx_q    <= last_idx_d;
      rem_q         <= rem_d;
      dst_q         <= dst_d;
      src_q         <= src_d;
      type_q        <= type_d;
      count_q       <= count_d;
      ifg_q         <= ifg_d;
      ifg_cnt_q     <= ifg_cnt_d;
      frames_sent_q <= frames_sent_d;
      stop_pend_q   <= stop_pend_d;
      done_q        <= done_d;
    end
  end

  assign axis_tx.tvalid = tvalid_w;
  assign axis_tx.tdata  = data_w;
  assign axis_tx.tkeep  = keep_w;
  assign axis_tx.tlast  = tvalid_w & last_beat;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign frames_sent    = frames_sent_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb/tb_axis_pkt_gen.sv - self-checking bench for axis_pkt_gen against a byte-level frame model
module tb_axis_pkt_gen;

  logic        clk160m = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [47:0] dst_mac = '0;
  logic [47:0] src_mac = '0;
  logic [15:0] ethertype = '0;
  logic [13:0] frame_len = '0;
  logic [31:0] frame_count = '0;
  logic [7:0]  ifg_cycles = '0;
  logic        busy, done;
  logic [31:0] frames_sent;

  axis_pkt_gen_if axis_tx ();

  axis_pkt_gen #(.MIN_LEN(60), .MAX_LEN(1514), .IFG_W(8)) dut (
    .clk160m     (clk160m),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .dst_mac     (dst_mac),
    .src_mac     (src_mac),
    .ethertype   (ethertype),
    .frame_len   (frame_len),
    .frame_count (frame_count),
    .ifg_cycles  (ifg_cycles),
    .axis_tx     (axis_tx),
    .busy        (busy),
    .done        (done),
    .frames_sent (frames_sent)
  );

  always #3 clk160m = ~clk160m;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_bytes[$];

  typedef struct {
    int         len;
    int         cnt;
    int         ifg;
    bit         rnd;
    int         smode;
    int         sframe;
    int         exp_frames;
    int         exp_beats;
    logic [7:0] exp_keep;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int clamp_len(input int n);
    return (n < 60) ? 60 : ((n > 1514) ? 1514 : n);
  endfunction

  // Whole frame as a byte list: header fields MSB first, sequence number, counting payload.
  function automatic void build_frame(input int len, input int seq);
    logic [31:0] s;
    s = 32'(seq);
    exp_bytes.delete();
    for (int j = 5; j >= 0; j--) exp_bytes.push_back(8'(dst_mac >> (8 * j)));
    for (int j = 5; j >= 0; j--) exp_bytes.push_back(8'(src_mac >> (8 * j)));
    for (int j = 1; j >= 0; j--) exp_bytes.push_back(8'(ethertype >> (8 * j)));
    for (int j = 3; j >= 0; j--) exp_bytes.push_back(8'(s >> (8 * j)));
    for (int i = 18; i < len; i++) exp_bytes.push_back(8'(i - 18));
  endfunction

  task automatic randomize_hdr();
    dst_mac   = 48'({$urandom, $urandom});
    src_mac   = 48'({$urandom, $urandom});
    ethertype = 16'($urandom);
  endtask

  // smode 1: stop at beat 3 of frame index sframe; smode 2: stop two idle cycles after sframe frames.
  task automatic run_burst(input int len_req, input int cnt, input int ifg, input bit rnd,
                           input int smode, input int sframe, input int exp_frames,
                           output int beats0, output logic [7:0] lastkeep0, output logic [63:0] beat0_data);
    int L, f, b, gap, cyc, extra;
    bit gap_armed, seen_done, stop_sent, rdy, prdy, pv, el;
    logic [63:0] pd, ed;
    logic [7:0]  pk, ek;
    logic        pl;
    L = clamp_len(len_req);
    f = 0; b = 0; gap = 0; cyc = 0;
    gap_armed = 0; seen_done = 0; stop_sent = 0; prdy = 1; pv = 0;
    pd = '0; pk = '0; pl = 1'b0;
    beats0 = 0; lastkeep0 = '0; beat0_data = '0;
    frame_len   = 14'(len_req);
    frame_count = 32'(cnt);
    ifg_cycles  = 8'(ifg);
    @(negedge clk160m);
    start = 1'b1;
    @(negedge clk160m);
    start = 1'b0;
    while (!seen_done && cyc < 20000) begin
      cyc++;
      stop = 1'b0;
      if (pv && !prdy) begin
        check("stall_valid", 64'(axis_tx.tvalid), 64'd1);
        check("stall_data", axis_tx.tdata, pd);
        check("stall_keep", 64'(axis_tx.tkeep), 64'(pk));
        check("stall_last", 64'(axis_tx.tlast), 64'(pl));
      end
      if (done) begin
        seen_done = 1;
      end else begin
        if (gap_armed) begin
          if (axis_tx.tvalid) begin
            check($sformatf("ifg_gap f%0d", f), 64'(gap), 64'(ifg));
            gap_armed = 0;
          end else begin
            gap++;
          end
        end
        if (smode == 1 && !stop_sent && f == sframe && b == 3 && axis_tx.tvalid) begin
          stop = 1'b1;
          stop_sent = 1;
        end
        if (smode == 2 && !stop_sent && f == sframe && gap_armed && gap == 2) begin
          stop = 1'b1;
          stop_sent = 1;
        end
        rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        axis_tx.tready = rdy;
        if (axis_tx.tvalid && rdy) begin
          if (b == 0) build_frame(L, f);
          ed = '0;
          ek = '0;
          for (int n = 0; n < 8; n++) begin
            if (8 * b + n < L) begin
              ed = ed | (64'(exp_bytes[8 * b + n]) << (8 * n));
              ek = ek | (8'd1 << n);
            end
          end
          el = (8 * b + 8 >= L);
          check($sformatf("data f%0d b%0d", f, b), axis_tx.tdata, ed);
          check($sformatf("keep f%0d b%0d", f, b), 64'(axis_tx.tkeep), 64'(ek));
          check($sformatf("last f%0d b%0d", f, b), 64'(axis_tx.tlast), 64'(el));
          if (f == 0 && b == 0) beat0_data = axis_tx.tdata;
          b++;
          if (el) begin
            if (f == 0) begin
              beats0 = b;
              lastkeep0 = axis_tx.tkeep;
            end
            f++;
            b = 0;
            gap = 0;
            gap_armed = 1;
          end
        end
        pv = axis_tx.tvalid;
        prdy = rdy;
        pd = axis_tx.tdata;
        pk = axis_tx.tkeep;
        pl = axis_tx.tlast;
        @(negedge clk160m);
      end
    end
    stop = 1'b0;
    axis_tx.tready = 1'b1;
    check("done_seen", 64'(seen_done), 64'd1);
    check("frames_received", 64'(f), 64'(exp_frames));
    check("frames_sent", 64'(frames_sent), 64'(exp_frames));
    check("busy_at_done", 64'(busy), 64'd0);
    @(negedge clk160m);
    check("done_one_cycle", 64'(done), 64'd0);
    extra = 0;
    repeat (8) begin
      @(negedge clk160m);
      if (axis_tx.tvalid) extra++;
    end
    check("quiet_after_done", 64'(extra), 64'd0);
  endtask

  initial begin
    int          beats0;
    logic [7:0]  lastkeep0;
    logic [63:0] beat0_data;
    int          len_r, cnt_r, ifg_r;

    tbl[0] = '{60,   1, 0,  1'b0, 0, 0, 1, 8,   8'h0F};
    tbl[1] = '{20,   1, 0,  1'b0, 0, 0, 1, 8,   8'h0F};
    tbl[2] = '{9000, 1, 0,  1'b0, 0, 0, 1, 190, 8'h03};
    tbl[3] = '{64,   1, 0,  1'b0, 0, 0, 1, 8,   8'hFF};
    tbl[4] = '{60,   3, 5,  1'b1, 0, 0, 3, 8,   8'h0F};
    tbl[5] = '{100,  2, 0,  1'b1, 0, 0, 2, 13,  8'h0F};
    tbl[6] = '{61,   0, 0,  1'b1, 1, 1, 2, 8,   8'h1F};
    tbl[7] = '{200,  0, 20, 1'b0, 2, 1, 1, 25,  8'hFF};

    axis_tx.tready = 1'b1;
    repeat (3) @(negedge clk160m);
    check("rst_tvalid", 64'(axis_tx.tvalid), 64'd0);
    check("rst_tdata", axis_tx.tdata, 64'd0);
    check("rst_tkeep", 64'(axis_tx.tkeep), 64'd0);
    check("rst_tlast", 64'(axis_tx.tlast), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_frames_sent", 64'(frames_sent), 64'd0);
    reset = 1'b0;
    @(negedge clk160m);

    for (int i = 0; i < 8; i++) begin
      randomize_hdr();
      run_burst(tbl[i].len, tbl[i].cnt, tbl[i].ifg, tbl[i].rnd, tbl[i].smode, tbl[i].sframe,
                tbl[i].exp_frames, beats0, lastkeep0, beat0_data);
      check($sformatf("row%0d_beats", i), 64'(beats0), 64'(tbl[i].exp_beats));
      check($sformatf("row%0d_lastkeep", i), 64'(lastkeep0), 64'(tbl[i].exp_keep));
      if (i == 0) begin
        check("beat0_layout", beat0_data,
              {src_mac[39:32], src_mac[47:40], dst_mac[7:0], dst_mac[15:8],
               dst_mac[23:16], dst_mac[31:24], dst_mac[39:32], dst_mac[47:40]});
      end
    end

    // Reset mid-frame with the sink stalled, then a fresh burst must restart at sequence 0.
    randomize_hdr();
    frame_len = 14'd200;
    frame_count = 32'd0;
    ifg_cycles = 8'd0;
    axis_tx.tready = 1'b0;
    @(negedge clk160m);
    start = 1'b1;
    @(negedge clk160m);
    start = 1'b0;
    repeat (3) @(negedge clk160m);
    check("pre_reset_tvalid", 64'(axis_tx.tvalid), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_tvalid", 64'(axis_tx.tvalid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk160m);
    reset = 1'b0;
    axis_tx.tready = 1'b1;
    @(negedge clk160m);
    check("post_rst_frames_sent", 64'(frames_sent), 64'd0);
    check("post_rst_tvalid", 64'(axis_tx.tvalid), 64'd0);
    run_burst(60, 1, 0, 1'b0, 0, 0, 1, beats0, lastkeep0, beat0_data);

    for (int r = 0; r < 5; r++) begin
      randomize_hdr();
      len_r = int'($urandom_range(0, 1600));
      cnt_r = int'($urandom_range(1, 3));
      ifg_r = int'($urandom_range(0, 4));
      run_burst(len_r, cnt_r, ifg_r, 1'b1, 0, 0, cnt_r, beats0, lastkeep0, beat0_data);
      check($sformatf("rand%0d_beats", r), 64'(beats0), 64'((clamp_len(len_r) + 7) / 8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
